// File: rtl/tx_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// tx_ctrl_pkg
// Shared definitions for the Tx control blocks:
//   - tx_state_e : burst scheduler state encoding
//   - MODE_*     : MODE_CTRL field values understood by the Tx chain
// -----------------------------------------------------------------------------
package tx_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CFG       = 3'd1,
        ST_WARMUP    = 3'd2,
        ST_START     = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_GAP       = 3'd5,
        ST_DRAIN     = 3'd6
    } tx_state_e;

    // MODE_CTRL field constants
    localparam logic [3:0] MODE_OFF       = 4'h0;
    localparam logic [3:0] MODE_BPSK      = 4'h1;
    localparam logic [3:0] MODE_QPSK      = 4'h2;
    localparam logic [3:0] MODE_8PSK      = 4'h3;
    localparam logic [3:0] MODE_TEST_TONE = 4'hF;

endpackage

// File: rtl/tx_burst_sched.sv
// -----------------------------------------------------------------------------
// tx_burst_sched
// Sequences one Tx burst through Tx_Data -> FIFO -> Packetizer -> PSK_Modulation
// in the 16.384 MHz domain. Configuration is captured only in CFG so it never
// changes mid-burst; the modulator is warmed up, packets are released one at a
// time with an enforced gap, and the modulator filter is drained at the end.
//
// Ports
//   clk_16M384, rst_16M384    clock, synchronous active-high reset
//   start, stop               one-cycle burst start / stop-after-packet requests
//   MODE_CTRL, TX_PHASE_CONFIG, DELAY_CNT   requested configuration
//   burst_len                 packets per burst, 0 = continuous until stop
//   pkt_done                  one-cycle packet-finished pulse (already synced)
//   mode_cfg, phase_cfg, delay_cfg          configuration latched in CFG
//   mod_en                    modulator / DAC path enable
//   pkt_start                 one-cycle release of the next packet
//   busy                      state is not IDLE
//   err_timeout               sticky packet-done timeout flag, cleared in CFG
//   pkt_count                 packets completed this burst, saturating
//
// Timed states use one shared down-counter: the state moves on at the clock
// where the counter is already zero, so a load of N lasts N+1 clocks.
// -----------------------------------------------------------------------------
module tx_burst_sched
    import tx_ctrl_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int WARMUP_CYC  = 64,
    parameter int GAP_CYC     = 256,
    parameter int DRAIN_CYC   = 128,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic             clk_16M384,
    input  logic             rst_16M384,
    input  logic             start,
    input  logic             stop,
    input  logic [3:0]       MODE_CTRL,
    input  logic [15:0]      TX_PHASE_CONFIG,
    input  logic [3:0]       DELAY_CNT,
    input  logic [7:0]       burst_len,
    input  logic             pkt_done,
    output logic [3:0]       mode_cfg,
    output logic [15:0]      phase_cfg,
    output logic [3:0]       delay_cfg,
    output logic             mod_en,
    output logic             pkt_start,
    output logic             busy,
    output logic             err_timeout,
    output logic [CNT_W-1:0] pkt_count
);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       rem_q, rem_d;
    logic             cont_q, cont_d;         // burst_len was 0: run until stop
    logic             stop_pend_q, stop_pend_d;
    logic [CNT_W-1:0] pkt_count_q, pkt_count_d;
    logic             err_q, err_d;
    logic [3:0]       mode_q, mode_d;
    logic [15:0]      phase_q, phase_d;
    logic [3:0]       delay_q, delay_d;
    logic             mod_en_q, mod_en_d;
    logic             pkt_start_q, pkt_start_d;
    logic             busy_q, busy_d;

    logic             stop_seen;

    assign stop_seen = stop | stop_pend_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        cont_d      = cont_q;
        stop_pend_d = stop_pend_q | stop;
        pkt_count_d = pkt_count_q;
        err_d       = err_q;
        mode_d      = mode_q;
        phase_d     = phase_q;
        delay_d     = delay_q;

        unique case (state_q)
            ST_IDLE: begin
                stop_pend_d = 1'b0;
                if (start && !stop) state_d = ST_CFG;
            end
            ST_CFG: begin
                stop_pend_d = 1'b0;
                mode_d      = MODE_CTRL;
                phase_d     = TX_PHASE_CONFIG;
                delay_d     = DELAY_CNT;
                rem_d       = burst_len;
                cont_d      = (burst_len == 8'd0);
                pkt_count_d = '0;
                err_d       = 1'b0;
                // extra warm-up of 16 clocks per DELAY_CNT step
                cnt_d       = CNT_W'(WARMUP_CYC) + (CNT_W'(DELAY_CNT) << 4);
                state_d     = ST_WARMUP;
            end
            ST_WARMUP: begin
                if (stop_seen) begin
                    cnt_d   = CNT_W'(DRAIN_CYC);
                    state_d = ST_DRAIN;
                end else if (cnt_q == '0) begin
                    state_d = ST_START;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_START: begin
                cnt_d   = CNT_W'(TIMEOUT_CYC);
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (pkt_done) begin
                    if (pkt_count_q != '1) pkt_count_d = pkt_count_q + CNT_W'(1);
                    if (!cont_q) rem_d = rem_q - 8'd1;
                    // rem_q == 1 means this packet was the last of the burst
                    if (stop_seen || (!cont_q && rem_q == 8'd1)) begin
                        cnt_d   = CNT_W'(DRAIN_CYC);
                        state_d = ST_DRAIN;
                    end else begin
                        cnt_d   = CNT_W'(GAP_CYC);
                        state_d = ST_GAP;
                    end
                end else if (cnt_q == '0) begin
                    err_d   = 1'b1;
                    cnt_d   = CNT_W'(DRAIN_CYC);
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (stop_seen) begin
                    cnt_d   = CNT_W'(DRAIN_CYC);
                    state_d = ST_DRAIN;
                end else if (cnt_q == '0) begin
                    state_d = ST_START;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register with it.
        mod_en_d    = (state_d == ST_WARMUP) || (state_d == ST_START) ||
                      (state_d == ST_WAIT_DONE) || (state_d == ST_GAP) ||
                      (state_d == ST_DRAIN);
        pkt_start_d = (state_d == ST_START);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_16M384) begin
        if (rst_16M384) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            cont_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            pkt_count_q <= '0;
            err_q       <= 1'b0;
            mode_q      <= '0;
            phase_q     <= '0;
            delay_q     <= '0;
            mod_en_q    <= 1'b0;
            pkt_start_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            cont_q      <= cont_d;
            stop_pend_q <= stop_pend_d;
            pkt_count_q <= pkt_count_d;
            err_q       <= err_d;
            mode_q      <= mode_d;
            phase_q     <= phase_d;
            delay_q     <= delay_d;
            mod_en_q    <= mod_en_d;
            pkt_start_q <= pkt_start_d;
            busy_q      <= busy_d;
        end
    end

    assign mode_cfg    = mode_q;
    assign phase_cfg   = phase_q;
    assign delay_cfg   = delay_q;
    assign mod_en      = mod_en_q;
    assign pkt_start   = pkt_start_q;
    assign busy        = busy_q;
    assign err_timeout = err_q;
    assign pkt_count   = pkt_count_q;

endmodule

// File: tb/tb_tx_burst_sched.sv
// -----------------------------------------------------------------------------
// tb_tx_burst_sched
// Directed bench for tx_burst_sched. A deadline-based model (absolute cycle
// numbers for each phase end) predicts every output each clock; directed
// scenarios add hand-computed latency / count expectations.
// -----------------------------------------------------------------------------
module tb_tx_burst_sched;
    import tx_ctrl_pkg::*;

    localparam int CNT_W = 16;
    localparam int WU    = 64;
    localparam int GP    = 256;
    localparam int DR    = 128;
    localparam int TO    = 65535;

    localparam int P_IDLE = 0, P_CFG = 1, P_WARM = 2, P_START = 3,
                   P_WAIT = 4, P_GAP = 5, P_DRAIN = 6;

    logic clk = 1'b0;
    always #30 clk = ~clk;

    logic             rst, start, stop, pkt_done;
    logic [3:0]       mode_in, delay_in;
    logic [15:0]      phase_in;
    logic [7:0]       bl;
    logic [3:0]       mode_cfg, delay_cfg;
    logic [15:0]      phase_cfg;
    logic             mod_en, pkt_start, busy, err_timeout;
    logic [CNT_W-1:0] pkt_count;

    tx_burst_sched #(
        .CNT_W(CNT_W), .WARMUP_CYC(WU), .GAP_CYC(GP), .DRAIN_CYC(DR), .TIMEOUT_CYC(TO)
    ) dut (
        .clk_16M384(clk), .rst_16M384(rst), .start(start), .stop(stop),
        .MODE_CTRL(mode_in), .TX_PHASE_CONFIG(phase_in), .DELAY_CNT(delay_in),
        .burst_len(bl), .pkt_done(pkt_done),
        .mode_cfg(mode_cfg), .phase_cfg(phase_cfg), .delay_cfg(delay_cfg),
        .mod_en(mod_en), .pkt_start(pkt_start), .busy(busy),
        .err_timeout(err_timeout), .pkt_count(pkt_count)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;   // index of the last rising edge
    int n_pstart = 0; // pkt_start pulses seen on the DUT
    bit chk_on = 1'b0;

    // ---------------- model ----------------
    int         m_ph = P_IDLE, m_end = 0, m_rem = 0, m_cnt = 0, m_bl = 0;
    logic       m_pend = 1'b0, m_err = 1'b0;
    logic [3:0] m_mode = '0, m_delay = '0;
    logic [15:0] m_phase = '0;

    always @(posedge clk) begin : model
        int n, ph, en, rem, cnt, blv;
        logic pend, err, s;
        logic [3:0] mo, dl;
        logic [15:0] pc;
        n = cyc + 1; ph = m_ph; en = m_end; rem = m_rem; cnt = m_cnt; blv = m_bl;
        pend = m_pend; err = m_err; mo = m_mode; dl = m_delay; pc = m_phase;
        if (rst) begin
            ph = P_IDLE; cnt = 0; err = 1'b0; mo = '0; dl = '0; pc = '0; pend = 1'b0; rem = 0;
        end else begin
            s = stop || pend;
            case (ph)
                P_IDLE: if (start && !stop) ph = P_CFG;
                P_CFG: begin
                    mo = mode_in; pc = phase_in; dl = delay_in; blv = int'(bl); rem = int'(bl);
                    cnt = 0; err = 1'b0; ph = P_WARM;
                    en = n + WU + 16 * int'(delay_in) + 1;
                end
                P_WARM: begin
                    if (s) begin ph = P_DRAIN; en = n + DR + 1; end
                    else if (n == en) ph = P_START;
                end
                P_START: begin ph = P_WAIT; en = n + TO + 1; end
                P_WAIT: begin
                    if (pkt_done) begin
                        if (cnt < 65535) cnt = cnt + 1;
                        if (blv != 0) rem = rem - 1;
                        if (s || (blv != 0 && rem == 0)) begin ph = P_DRAIN; en = n + DR + 1; end
                        else begin ph = P_GAP; en = n + GP + 1; end
                    end else if (n == en) begin
                        err = 1'b1; ph = P_DRAIN; en = n + DR + 1;
                    end
                end
                P_GAP: begin
                    if (s) begin ph = P_DRAIN; en = n + DR + 1; end
                    else if (n == en) ph = P_START;
                end
                P_DRAIN: if (n == en) ph = P_IDLE;
                default: ph = P_IDLE;
            endcase
            pend = (m_ph == P_IDLE || m_ph == P_CFG) ? 1'b0 : (pend || stop);
        end
        m_ph <= ph; m_end <= en; m_rem <= rem; m_cnt <= cnt; m_bl <= blv;
        m_pend <= pend; m_err <= err; m_mode <= mo; m_delay <= dl; m_phase <= pc;
        cyc <= n;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: bound expired (cycle %0d)", nm, cyc);
    endtask

    // per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_on) begin
            check("mod_en",      {31'b0, mod_en},      {31'b0, (m_ph >= P_WARM)});
            check("busy",        {31'b0, busy},        {31'b0, (m_ph != P_IDLE)});
            check("pkt_start",   {31'b0, pkt_start},   {31'b0, (m_ph == P_START)});
            check("err_timeout", {31'b0, err_timeout}, {31'b0, m_err});
            check("pkt_count",   {16'b0, pkt_count},   32'(m_cnt));
            check("mode_cfg",    {28'b0, mode_cfg},    {28'b0, m_mode});
            check("phase_cfg",   {16'b0, phase_cfg},   {16'b0, m_phase});
            check("delay_cfg",   {28'b0, delay_cfg},   {28'b0, m_delay});
            if (pkt_start === 1'b1) n_pstart++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_start(output int t0);
        start = 1'b1; t0 = cyc + 1; tick(); start = 1'b0;
    endtask

    task automatic wait_pstart(output int t, input int lim);
        t = -1;
        for (int i = 0; i < lim; i++) begin
            tick();
            if (pkt_start === 1'b1) begin t = cyc; break; end
        end
        if (t < 0) begin fail_now("wait_pkt_start"); t = cyc; end
    endtask

    // pkt_done sampled at rising edge s+dly
    task automatic done_at(input int s, input int dly, input logic with_stop);
        while (cyc < s + dly - 1) tick();
        pkt_done = 1'b1; stop = with_stop; tick(); pkt_done = 1'b0; stop = 1'b0;
    endtask

    task automatic wait_idle(output int t, input int lim);
        t = -1;
        for (int i = 0; i < lim; i++) begin
            tick();
            if (busy === 1'b0) begin t = cyc; break; end
        end
        if (t < 0) begin fail_now("wait_idle"); t = cyc; end
    endtask

    initial begin
        #5_700_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, s, s2, d, ti, base;
        rst = 1'b1; start = 1'b0; stop = 1'b0; pkt_done = 1'b0;
        mode_in = MODE_BPSK; phase_in = 16'h0A5A; delay_in = 4'd2; bl = 8'd3;
        tick();
        chk_on = 1'b1;
        tick();
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_mod_en", {31'b0, mod_en}, 32'd0);
        check("rst_mode_cfg", {28'b0, mode_cfg}, 32'd0);
        rst = 1'b0;
        tick();

        // 1: burst of 3, DELAY_CNT=2
        pulse_start(t0);
        wait_pstart(s, 200);
        check("t1_first_latency", 32'(s - t0), 32'd98);
        done_at(s, 100, 1'b0);
        wait_pstart(s2, 400);
        check("t1_spacing_2", 32'(s2 - s), 32'd357);
        done_at(s2, 100, 1'b0);
        wait_pstart(s, 400);
        check("t1_spacing_3", 32'(s - s2), 32'd357);
        done_at(s, 100, 1'b0);
        d = cyc;
        check("t1_pkt_count", {16'b0, pkt_count}, 32'd3);
        while (cyc < d + DR) tick();
        check("t1_drain_busy", {31'b0, busy}, 32'd1);
        tick();
        check("t1_idle_busy", {31'b0, busy}, 32'd0);
        check("t1_idle_mod_en", {31'b0, mod_en}, 32'd0);
        check("t1_mode_held", {28'b0, mode_cfg}, {28'b0, MODE_BPSK});

        // 2: timeout, burst_len=1, no pkt_done
        bl = 8'd1; delay_in = 4'd0;
        pulse_start(t0);
        wait_pstart(s, 200);
        check("t2_first_latency", 32'(s - t0), 32'd66);
        while (cyc < s + TO + 1) tick();
        check("t2_err_before", {31'b0, err_timeout}, 32'd0);
        tick();
        check("t2_err_after", {31'b0, err_timeout}, 32'd1);
        d = cyc;
        wait_idle(ti, 300);
        check("t2_drain_len", 32'(ti - d), 32'd129);
        check("t2_pkt_count", {16'b0, pkt_count}, 32'd0);
        check("t2_err_sticky", {31'b0, err_timeout}, 32'd1);

        // 3: continuous, stop in GAP after packet 5
        bl = 8'd0; delay_in = 4'd1;
        base = n_pstart;
        pulse_start(t0);
        tick();
        check("t3_err_cleared", {31'b0, err_timeout}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            wait_pstart(s, 500);
            if (k == 0) check("t3_first_latency", 32'(s - t0), 32'd82);
            done_at(s, 100, 1'b0);
        end
        d = cyc;
        while (cyc < d + 49) tick();
        stop = 1'b1; tick(); stop = 1'b0;
        wait_idle(ti, 400);
        check("t3_drain_len", 32'(ti - (d + 50)), 32'd129);
        check("t3_pulses", 32'(n_pstart - base), 32'd5);
        check("t3_pkt_count", {16'b0, pkt_count}, 32'd5);

        // 4: stop with pkt_done on packet 2, then stop during WARMUP
        bl = 8'd5; delay_in = 4'd0;
        pulse_start(t0);
        wait_pstart(s, 200);
        done_at(s, 100, 1'b0);
        wait_pstart(s, 400);
        done_at(s, 100, 1'b1);
        d = cyc;
        check("t4_pkt_count", {16'b0, pkt_count}, 32'd2);
        wait_idle(ti, 300);
        check("t4_drain_len", 32'(ti - d), 32'd129);
        base = n_pstart;
        pulse_start(t0);
        while (cyc < t0 + 9) tick();
        stop = 1'b1; tick(); stop = 1'b0;
        wait_idle(ti, 300);
        check("t4_warm_stop_len", 32'(ti - (t0 + 10)), 32'd129);
        check("t4_no_pulses", 32'(n_pstart - base), 32'd0);
        check("t4_pkt_count0", {16'b0, pkt_count}, 32'd0);

        // 5: configuration isolation
        mode_in = MODE_QPSK; phase_in = 16'h1234; delay_in = 4'd3; bl = 8'd2;
        pulse_start(t0);
        tick();
        mode_in = MODE_TEST_TONE; phase_in = 16'hBEEF; delay_in = 4'd7;
        check("t5_mode", {28'b0, mode_cfg}, {28'b0, MODE_QPSK});
        check("t5_phase", {16'b0, phase_cfg}, 32'h1234);
        check("t5_delay", {28'b0, delay_cfg}, 32'd3);
        wait_pstart(s, 300);
        check("t5_first_latency", 32'(s - t0), 32'd114);
        repeat (10) tick();
        start = 1'b1; tick(); start = 1'b0;
        check("t5_phase_busy_start", {16'b0, phase_cfg}, 32'h1234);
        done_at(s, 100, 1'b0);
        wait_pstart(s2, 400);
        check("t5_spacing", 32'(s2 - s), 32'd357);
        done_at(s2, 100, 1'b0);
        wait_idle(ti, 300);
        check("t5_mode_held", {28'b0, mode_cfg}, {28'b0, MODE_QPSK});
        pulse_start(t1);
        tick();
        check("t5_mode_new", {28'b0, mode_cfg}, {28'b0, MODE_TEST_TONE});
        check("t5_phase_new", {16'b0, phase_cfg}, 32'hBEEF);
        check("t5_delay_new", {28'b0, delay_cfg}, 32'd7);
        stop = 1'b1; tick(); stop = 1'b0;
        wait_idle(ti, 300);

        // 6: reset during WAIT_DONE, then a late pkt_done
        bl = 8'd1; delay_in = 4'd0;
        pulse_start(t0);
        wait_pstart(s, 200);
        repeat (20) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check("t6_busy", {31'b0, busy}, 32'd0);
        check("t6_mod_en", {31'b0, mod_en}, 32'd0);
        check("t6_phase_cfg", {16'b0, phase_cfg}, 32'd0);
        repeat (5) tick();
        pkt_done = 1'b1; tick(); pkt_done = 1'b0;
        tick();
        check("t6_late_done_count", {16'b0, pkt_count}, 32'd0);
        check("t6_late_done_busy", {31'b0, busy}, 32'd0);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
